// File: rtl/wb_slave_decoder.sv
// Wishbone 1-to-N address decoder: one outstanding transfer, registered response,
// decode errors and (with `define WB_DECODER_TIMEOUT_EN) slave timeouts complete with ERR_DATA.
module wb_slave_decoder #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       N_SLAVES       = 4,
  parameter int unsigned       SEL_LSB        = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  input  logic                         m_we_i,
  input  logic [DATA_W/8-1:0]          m_sel_i,
  input  logic                         m_stb_i,
  input  logic                         m_cyc_i,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_ack_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic                         s_we_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  output logic [N_SLAVES-1:0]          s_cyc_o,
  output logic [N_SLAVES-1:0]          s_stb_o,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
  input  logic [N_SLAVES-1:0]          s_ack_i,
  output logic                         err_o,
  output logic [ADDR_W-1:0]            err_addr_o
);

  if (N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_slave_decoder: N_SLAVES must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                state_r, state_s;
  logic [3:0]            idx_r, idx_s;
  logic [N_SLAVES-1:0]   stb_r, stb_s;
  logic [ADDR_W-1:0]     s_addr_r, s_addr_s;
  logic [DATA_W-1:0]     s_wdata_r, s_wdata_s;
  logic                  s_we_r, s_we_s;
  logic [DATA_W/8-1:0]   s_sel_r, s_sel_s;
  logic [DATA_W-1:0]     m_rdata_r, m_rdata_s;
  logic                  m_ack_r, m_ack_s;
  logic                  err_r, err_s;
  logic [ADDR_W-1:0]     err_addr_r, err_addr_s;

  logic [3:0]            req_idx_s;
  logic                  req_hit_s;
  logic                  ack_sel_s;
  logic [DATA_W-1:0]     rdata_sel_s;
  logic                  timeout_s;

  assign req_idx_s = m_addr_i[SEL_LSB+3:SEL_LSB];
  assign req_hit_s = ({1'b0, req_idx_s} < 5'(N_SLAVES));

`ifdef WB_DECODER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r, cnt_s;
  // Expires on the edge where the count of ack-less ACTIVE edges reaches TIMEOUT_CYCLES.
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Select ack and read data of the slave owning the outstanding transfer.
  always_comb begin
    ack_sel_s   = 1'b0;
    rdata_sel_s = {DATA_W{1'b0}};
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      ack_sel_s   = ack_sel_s | (s_ack_i[i] & (idx_r == 4'(i)));
      rdata_sel_s = rdata_sel_s | (s_rdata_i[i*DATA_W +: DATA_W] & {DATA_W{idx_r == 4'(i)}});
    end
  end

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    stb_s      = stb_r;
    s_addr_s   = s_addr_r;
    s_wdata_s  = s_wdata_r;
    s_we_s     = s_we_r;
    s_sel_s    = s_sel_r;
    m_rdata_s  = m_rdata_r;
    m_ack_s    = 1'b0;
    err_s      = 1'b0;
    err_addr_s = err_addr_r;
`ifdef WB_DECODER_TIMEOUT_EN
    cnt_s      = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (req_hit_s) begin
            s_addr_s  = m_addr_i;
            s_wdata_s = m_wdata_i;
            s_we_s    = m_we_i;
            s_sel_s   = m_sel_i;
            stb_s     = N_SLAVES'(1'b1) << req_idx_s;
            idx_s     = req_idx_s;
`ifdef WB_DECODER_TIMEOUT_EN
            cnt_s     = {CNT_W{1'b0}};
`endif
            state_s   = ST_ACTIVE;
          end else begin
            m_ack_s    = 1'b1;
            m_rdata_s  = ERR_DATA;
            err_s      = 1'b1;
            err_addr_s = m_addr_i;
            state_s    = ST_RESP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Abort beats ack, ack beats timeout.
        if (!m_cyc_i) begin
          stb_s   = {N_SLAVES{1'b0}};
          state_s = ST_IDLE;
        end else if (ack_sel_s) begin
          stb_s     = {N_SLAVES{1'b0}};
          m_ack_s   = 1'b1;
          m_rdata_s = rdata_sel_s;
          state_s   = ST_RESP;
        end else if (timeout_s) begin
          stb_s      = {N_SLAVES{1'b0}};
          m_ack_s    = 1'b1;
          m_rdata_s  = ERR_DATA;
          err_s      = 1'b1;
          err_addr_s = s_addr_r;
          state_s    = ST_RESP;
        end else begin
`ifdef WB_DECODER_TIMEOUT_EN
          cnt_s   = cnt_r + CNT_W'(1'b1);
`endif
          state_s = ST_ACTIVE;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        stb_s   = {N_SLAVES{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r    <= ST_IDLE;
      idx_r      <= 4'd0;
      stb_r      <= {N_SLAVES{1'b0}};
      s_addr_r   <= {ADDR_W{1'b0}};
      s_wdata_r  <= {DATA_W{1'b0}};
      s_we_r     <= 1'b0;
      s_sel_r    <= {(DATA_W/8){1'b0}};
      m_rdata_r  <= {DATA_W{1'b0}};
      m_ack_r    <= 1'b0;
      err_r      <= 1'b0;
      err_addr_r <= {ADDR_W{1'b0}};
`ifdef WB_DECODER_TIMEOUT_EN
      cnt_r      <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      stb_r      <= stb_s;
      s_addr_r   <= s_addr_s;
      s_wdata_r  <= s_wdata_s;
      s_we_r     <= s_we_s;
      s_sel_r    <= s_sel_s;
      m_rdata_r  <= m_rdata_s;
      m_ack_r    <= m_ack_s;
      err_r      <= err_s;
      err_addr_r <= err_addr_s;
`ifdef WB_DECODER_TIMEOUT_EN
      cnt_r      <= cnt_s;
`endif
    end
  end

  assign m_rdata_o  = m_rdata_r;
  assign m_ack_o    = m_ack_r;
  assign s_addr_o   = s_addr_r;
  assign s_wdata_o  = s_wdata_r;
  assign s_we_o     = s_we_r;
  assign s_sel_o    = s_sel_r;
  assign s_cyc_o    = stb_r;
  assign s_stb_o    = stb_r;
  assign err_o      = err_r;
  assign err_addr_o = err_addr_r;

endmodule
